// File: rtl/mlp_pkg.sv
// Shared types and width helpers for the streaming two-layer MLP engine.
// Holds the FSM state enum, accumulator widths, weight map base and narrowing.
package mlp_pkg;

    typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

    function automatic int hid_w(int n_in, int dw);
        return 2 * dw + $clog2(n_in);
    endfunction

    function automatic int out_w(int n_in, int n_hid, int dw);
        return hid_w(n_in, dw) + dw + $clog2(n_hid);
    endfunction

    function automatic int w2_base(int n_in, int n_hid);
        return n_in * n_hid;
    endfunction

    function automatic int idx_w(int n_in, int n_hid);
        int m;
        m = (n_in > n_hid) ? n_in : n_hid;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Wrap leaves v untouched; the caller's truncation does the wrapping.
    function automatic logic signed [63:0] narrow(
        logic signed [63:0] v, int w, bit sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (!sat) return v;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/mlp_stream_engine_if.sv
// Input and output valid/ready streams of the MLP engine.
// master drives in_data/in_valid/out_ready; slave drives in_ready/out_data/out_valid.
interface mlp_stream_engine_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int DW    = 5,
    parameter int ACC_W = 17
) ();
    logic [N_IN*DW-1:0]     in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_OUT*ACC_W-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/mlp_mac_lane.sv
// One signed multiply-accumulate lane with synchronous clear and enable.
// Ports: clk, rst_n, clr, en, a, b in; acc (register) and acc_nxt (acc + a*b) out.
module mlp_mac_lane #(
    parameter int AW    = 5,
    parameter int BW    = 5,
    parameter int ACC_W = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [AW-1:0]    a,
    input  logic signed [BW-1:0]    b,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] acc_nxt
);
    logic signed [AW+BW-1:0]  prod;
    logic signed [ACC_W-1:0]  prod_x;

    assign prod    = a * b;
    assign prod_x  = ACC_W'(prod);
    assign acc_nxt = acc + prod_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= acc_nxt;
    end
endmodule

// File: rtl/mlp_stream_engine.sv
// Time-multiplexed two-layer MLP: ReLU hidden layer, linear output layer.
// Ports: clk, rst_n, s (in/out streams), wr_en/wr_addr/wr_data weight port, wr_err.
module mlp_stream_engine import mlp_pkg::*; #(
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int DW    = 5,
    parameter int ACC_W = 17,
    parameter int SAT   = 0,
    localparam int NW   = w2_base(N_IN, N_HID) + N_HID * N_OUT,
    localparam int AW   = $clog2(NW)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mlp_stream_engine_if.slave   s,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [DW-1:0] wr_data,
    output logic                 wr_err
);
    localparam int HW  = hid_w(N_IN, DW);
    localparam int OW  = out_w(N_IN, N_HID, DW);
    localparam int IW  = idx_w(N_IN, N_HID);
    localparam int W2B = w2_base(N_IN, N_HID);

    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic accept, h_en, o_clr, o_en, load;
    logic in_ready_q, out_valid_q, wr_ok;
    logic [N_OUT*ACC_W-1:0] out_q;

    logic signed [DW-1:0] x      [N_IN];
    logic signed [DW-1:0] w1     [N_HID][N_IN];
    logic signed [DW-1:0] w2     [N_OUT][N_HID];
    logic signed [DW-1:0] w1_sel [N_HID];
    logic signed [DW-1:0] w2_sel [N_OUT];
    logic signed [DW-1:0] x_sel;
    logic signed [HW-1:0] h_sel;
    logic signed [HW-1:0] acc_h        [N_HID];
    logic signed [HW-1:0] h_nxt_unused [N_HID];
    logic signed [OW-1:0] acc_o        [N_OUT];
    logic signed [OW-1:0] o_nxt        [N_OUT];

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_q;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        accept  = 1'b0;
        h_en    = 1'b0;
        o_clr   = 1'b0;
        o_en    = 1'b0;
        load    = 1'b0;
        unique case (state)
            IDLE: if (s.in_valid && in_ready_q) begin
                accept  = 1'b1;
                idx_n   = '0;
                state_n = L1;
            end
            L1: begin
                h_en = 1'b1;
                if (idx == IW'(N_IN - 1)) begin
                    idx_n   = '0;
                    o_clr   = 1'b1;
                    state_n = L2;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            L2: begin
                o_en = 1'b1;
                if (idx == IW'(N_HID - 1)) begin
                    idx_n   = '0;
                    load    = 1'b1;
                    state_n = DONE;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            DONE: if (out_valid_q && s.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand muxes: one fan-in term per cycle, shared by all lanes.
    always_comb begin
        x_sel = '0;
        h_sel = '0;
        for (int h = 0; h < N_HID; h++) w1_sel[h] = '0;
        for (int o = 0; o < N_OUT; o++) w2_sel[o] = '0;
        for (int i = 0; i < N_IN; i++)
            if (idx == IW'(i)) x_sel = x[i];
        for (int h = 0; h < N_HID; h++)
            if (idx == IW'(h)) h_sel = acc_h[h][HW-1] ? '0 : acc_h[h];
        for (int h = 0; h < N_HID; h++)
            for (int i = 0; i < N_IN; i++)
                if (idx == IW'(i)) w1_sel[h] = w1[h][i];
        for (int o = 0; o < N_OUT; o++)
            for (int h = 0; h < N_HID; h++)
                if (idx == IW'(h)) w2_sel[o] = w2[o][h];
    end

    for (genvar h = 0; h < N_HID; h++) begin : g_hid
        mlp_mac_lane #(.AW(DW), .BW(DW), .ACC_W(HW)) u_lane (
            .clk(clk), .rst_n(rst_n), .clr(accept), .en(h_en),
            .a(x_sel), .b(w1_sel[h]),
            .acc(acc_h[h]), .acc_nxt(h_nxt_unused[h])
        );
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_out
        mlp_mac_lane #(.AW(HW), .BW(DW), .ACC_W(OW)) u_lane (
            .clk(clk), .rst_n(rst_n), .clr(o_clr), .en(o_en),
            .a(h_sel), .b(w2_sel[o]),
            .acc(acc_o[o]), .acc_nxt(o_nxt[o])
        );
    end

    assign wr_ok = wr_en && (state == IDLE) && (32'(wr_addr) < NW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
            for (int h = 0; h < N_HID; h++)
                for (int i = 0; i < N_IN; i++) w1[h][i] <= '0;
            for (int o = 0; o < N_OUT; o++)
                for (int h = 0; h < N_HID; h++) w2[o][h] <= '0;
        end else begin
            wr_err <= wr_en && !wr_ok;
            if (wr_ok) begin
                for (int h = 0; h < N_HID; h++)
                    for (int i = 0; i < N_IN; i++)
                        if (wr_addr == AW'(h * N_IN + i))
                            w1[h][i] <= wr_data;
                for (int o = 0; o < N_OUT; o++)
                    for (int h = 0; h < N_HID; h++)
                        if (wr_addr == AW'(W2B + o * N_HID + h))
                            w2[o][h] <= wr_data;
            end
        end
    end

    // The last L2 term lands in acc_nxt on the same edge out_q is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int i = 0; i < N_IN; i++) x[i] <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            in_ready_q <= (state_n == IDLE);
            if (accept)
                for (int i = 0; i < N_IN; i++)
                    x[i] <= s.in_data[i*DW +: DW];
            if (load) begin
                out_valid_q <= 1'b1;
                for (int o = 0; o < N_OUT; o++)
                    out_q[o*ACC_W +: ACC_W] <= ACC_W'(
                        narrow(64'(o_nxt[o]), ACC_W, SAT != 0));
            end else if (state == DONE && s.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/mlp_stream_engine.md
Name: mlp_stream_engine

Overview:
- Parametrised successor of the fixed 4-4-2 `top` network: two-layer MLP with N_IN inputs, N_HID ReLU hidden neurons and N_OUT linear outputs.
- Signed weights live in an internal register file written through a weight port.
- Inputs use a valid/ready handshake; outputs use a valid/ready handshake with backpressure.
- Compute is time-multiplexed: all neurons of a layer run in parallel, iterating over their fan-in one term per cycle.

Parameters:
N_IN, 4, number of inputs
N_HID, 4, number of hidden neurons
N_OUT, 2, number of outputs
DW, 5, signed width of inputs and weights
ACC_W, 17, signed width of each output word
SAT, 0, 0 = wrap output to ACC_W bits, 1 = saturate to ACC_W signed range

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  N_IN*DW  input vector; x[i] = in_data[i*DW +: DW], signed
in_valid  in  1  input vector present
in_ready  out  1  engine can accept an input vector
wr_en  in  1  weight write strobe
wr_addr  in  clog2(N_IN*N_HID+N_HID*N_OUT)  weight address
wr_data  in  DW  signed weight value
wr_err  out  1  one-cycle pulse: write rejected
out_data  out  N_OUT*ACC_W  outputs; y[o] = out_data[o*ACC_W +: ACC_W], signed
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data

Behaviour:
- Reset (async assert, sync release): state IDLE; all weights 0; in_ready 0 while rst_n low, 1 from the first edge after release; out_valid 0; out_data 0; wr_err 0. Assertion mid-computation aborts the computation and clears all weights.
- Weight map:
  - Layer-1 weight w1[h][i] at address h*N_IN+i.
  - Layer-2 weight w2[o][h] at address N_IN*N_HID + o*N_HID + h.
- Weight writes:
  - Applied only in IDLE and only when the address is in range.
  - Otherwise the write is dropped and wr_err pulses on the next cycle.
  - A write in the same cycle as an input accept is applied, and the new weight is used by that computation.
- States: IDLE -> L1 -> L2 -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid&&in_ready: latch in_data, clear hidden accumulators, idx=0, go to L1.
- L1:
  - Each edge: acc_h[h] += x[idx]*w1[h][idx] for all h; idx++.
  - After the edge with idx=N_IN-1: idx=0, clear output accumulators, go to L2.
  - Hidden accumulator width: HW = 2*DW + clog2(N_IN) (12 by default); no overflow is possible.
- L2:
  - Each edge: acc_o[o] += relu(acc_h[idx])*w2[o][idx]; relu(v) = v<0 ? 0 : v. Full width HW+DW+clog2(N_HID).
  - After the edge with idx=N_HID-1: load out_data from acc_o, set out_valid, go to DONE.
- Output narrowing to ACC_W:
  - SAT=0: keep the low ACC_W bits (two's-complement wrap).
  - SAT=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Latency: out_valid rises N_IN+N_HID edges after the accept edge (8 cycles by default).
- DONE:
  - out_data and out_valid held stable until out_valid&&out_ready.
  - On that edge: out_valid 0, go to IDLE. out_data retains its last value.
  - in_ready is 0 in L1, L2 and DONE; there is no overlap. Peak throughput is one vector per N_IN+N_HID+2 cycles.
- in_valid outside IDLE is ignored; in_data is not re-sampled.
- All signed products are sign-extended before accumulation.

Decomposition:
- Package mlp_pkg:
  - state enum {IDLE, L1, L2, DONE}.
  - Width functions for HW and the output accumulator width.
  - Weight address base constant function.
  - Saturate/wrap function.
- Sub-module mlp_mac_lane:
  - Parameterised one signed multiply-accumulate lane with clear and enable.
  - Instantiated N_HID times for L1 and N_OUT times for L2, with the accumulator width as a parameter.

Test Plan:
- Defaults; write weights 3,2,13,-6 / -9,1,-4,14 / 3,6,-15,15 / 9,-10,15,-10 (rows h), w2 rows 0,-1,3,-11 / -12,-15,-15,6; x=4,2,4,1 -> y0=-726, y1=-348, out_valid exactly 8 cycles after accept.
- Same x; w1 rows 3,2,13,0 / 0,0,0,14 / 3,6,0,15 / 9,0,15,0; w2 rows 0,0,3,11 / 12,0,0,6 -> y0=1173, y1=1392.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_data stable, in_ready 0, in_valid pulses ignored; on release, a single handshake, then in_ready=1.
- ACC_W=16; all x=-16, all w1=-16, all w2=-16 (pre-narrow -65536) -> SAT=0 y=0; SAT=1 y=-32768.
- wr_en during L1, and an out-of-range address in IDLE -> wr_err pulse on each, weights unchanged, results as in test 1.
- rst_n low during L2 -> out_valid 0, in_ready 1 after release; rerun with zero weights gives y0=y1=0.
